// File: rtl/am_key_param_ctrl.sv
// rtl/am_key_param_ctrl.sv - key-driven AM carrier FCW / modulation depth controller
//
// Purpose: turns debounced key scanner events into a saturating carrier
// frequency control word and modulation depth, one step per key press.
// Optional feature macro: KEY_AUTOREPEAT_EN (holding a key repeats the step).
//
// Ports:
//   clk_in        in   1   system clock
//   rst           in   1   asynchronous active-low reset
//   key_code      in   4   0 none, 1 FCW up, 2 FCW down, 3 depth up, 4 depth down (async)
//   key_pressed   in   1   scanner pressed flag (async)
//   fcw           out  32  carrier frequency control word
//   depth         out  8   modulation depth
//   param_update  out  1   one-cycle pulse when fcw or depth changes
module am_key_param_ctrl #(
   parameter logic [31:0] FCW_DEFAULT   = 32'd85899346,
   parameter logic [31:0] FCW_STEP      = 32'd4294967,
   parameter logic [31:0] FCW_MIN       = 32'd4294967,
   parameter logic [31:0] FCW_MAX       = 32'd858993459,
   parameter logic [7:0]  DEPTH_DEFAULT = 8'd128,
   parameter logic [7:0]  DEPTH_STEP    = 8'd16,
   parameter int unsigned REPEAT_DELAY  = 25_000_000,
   parameter int unsigned REPEAT_RATE   = 5_000_000
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic [3:0]  key_code,
   input  logic        key_pressed,
   output logic [31:0] fcw,
   output logic [7:0]  depth,
   output logic        param_update
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_APPLY = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   logic [3:0]  r_code_s1;
   logic [3:0]  r_code_s2;
   logic        r_pr_s1;
   logic        r_pr_s2;
   logic        r_pr_d;
   logic [1:0]  r_fill;
   logic        r_armed;
   logic [1:0]  r_state;
   logic [3:0]  r_code;
   logic [31:0] r_fcw;
   logic [7:0]  r_depth;
   logic        r_update;

   logic        w_code_valid;
   logic        w_rise;
   logic        w_rep_fire;
   logic        w_step;
   logic [32:0] w_fcw_up;
   logic [32:0] w_fcw_floor;
   logic [8:0]  w_depth_up;
   logic [31:0] w_fcw_next;
   logic [7:0]  w_depth_next;

   // A code is trusted only once both synchronizer stages agree on it.
   assign w_code_valid = (r_code_s1 == r_code_s2) &&
                         (r_code_s2 >= 4'd1) && (r_code_s2 <= 4'd4);

   // r_armed blocks a key that was already down across reset: it only sets
   // once the synchronizer holds real samples (r_fill == 2) showing release.
   assign w_rise = r_pr_s2 && !r_pr_d && r_armed;

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_code_s1 <= 4'd0;
         r_code_s2 <= 4'd0;
         r_pr_s1   <= 1'b0;
         r_pr_s2   <= 1'b0;
         r_pr_d    <= 1'b0;
         r_fill    <= 2'd0;
         r_armed   <= 1'b0;
      end else begin
         r_code_s1 <= key_code;
         r_code_s2 <= r_code_s1;
         r_pr_s1   <= key_pressed;
         r_pr_s2   <= r_pr_s1;
         r_pr_d    <= r_pr_s2;
         if (r_fill != 2'd2) begin
            r_fill <= r_fill + 2'd1;
         end
         if ((r_fill == 2'd2) && !r_pr_s2) begin
            r_armed <= 1'b1;
         end
      end
   end

`ifdef KEY_AUTOREPEAT_EN
   // Fire compares against interval-1 so repeats land exactly REPEAT_DELAY
   // cycles after entering HOLD, then every REPEAT_RATE cycles.
   localparam logic [25:0] DELAY_LAST = 26'(REPEAT_DELAY - 1);
   localparam logic [25:0] RATE_LAST  = 26'(REPEAT_RATE - 1);

   logic [25:0] r_rep_cnt;
   logic        r_rep_first;

   assign w_rep_fire = (r_state == S_HOLD) && r_pr_s2 &&
                       (r_rep_cnt == (r_rep_first ? DELAY_LAST : RATE_LAST));

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_rep_cnt   <= 26'd0;
         r_rep_first <= 1'b1;
      end else if (r_state != S_HOLD) begin
         r_rep_cnt   <= 26'd0;
         r_rep_first <= 1'b1;
      end else if (r_pr_s2) begin
         if (w_rep_fire) begin
            r_rep_cnt   <= 26'd0;
            r_rep_first <= 1'b0;
         end else begin
            r_rep_cnt <= r_rep_cnt + 26'd1;
         end
      end
   end
`else
   assign w_rep_fire = 1'b0;
`endif

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_code  <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_rise && w_code_valid) begin
                  r_code  <= r_code_s2;
                  r_state <= S_APPLY;
               end
            end
            S_APPLY: r_state <= S_HOLD;
            S_HOLD: begin
               // Code changes while held are ignored; only release re-arms.
               if (!r_pr_s2) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_step      = (r_state == S_APPLY) || w_rep_fire;
   assign w_fcw_up    = {1'b0, r_fcw} + {1'b0, FCW_STEP};
   assign w_fcw_floor = {1'b0, FCW_MIN} + {1'b0, FCW_STEP};
   assign w_depth_up  = {1'b0, r_depth} + {1'b0, DEPTH_STEP};

   // Widened arithmetic so a step near either clamp cannot wrap.
   always_comb begin
      w_fcw_next   = r_fcw;
      w_depth_next = r_depth;
      case (r_code)
         4'd1: w_fcw_next = (w_fcw_up > {1'b0, FCW_MAX}) ? FCW_MAX : w_fcw_up[31:0];
         4'd2: w_fcw_next = ({1'b0, r_fcw} < w_fcw_floor) ? FCW_MIN : (r_fcw - FCW_STEP);
         4'd3: w_depth_next = (w_depth_up > 9'd255) ? 8'd255 : w_depth_up[7:0];
         4'd4: w_depth_next = (r_depth < DEPTH_STEP) ? 8'd0 : (r_depth - DEPTH_STEP);
         default: begin
            w_fcw_next   = r_fcw;
            w_depth_next = r_depth;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_fcw    <= FCW_DEFAULT;
         r_depth  <= DEPTH_DEFAULT;
         r_update <= 1'b0;
      end else begin
         r_update <= 1'b0;
         if (w_step) begin
            r_fcw    <= w_fcw_next;
            r_depth  <= w_depth_next;
            r_update <= (w_fcw_next != r_fcw) || (w_depth_next != r_depth);
         end
      end
   end

   assign fcw          = r_fcw;
   assign depth        = r_depth;
   assign param_update = r_update;

endmodule

// File: tb/tb_am_key_param_ctrl.sv
// tb/tb_am_key_param_ctrl.sv - scoreboard testbench for am_key_param_ctrl
module tb_am_key_param_ctrl;

   localparam int P_FCW_DEF  = 1000;
   localparam int P_FCW_STEP = 100;
   localparam int P_FCW_MIN  = 950;
   localparam int P_FCW_MAX  = 1500;
   localparam int P_DEP_DEF  = 128;
   localparam int P_DEP_STEP = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  key_code = 4'd0;
   logic        key_pressed = 1'b0;
   logic [31:0] fcw;
   logic [7:0]  depth;
   logic        param_update;

   int checks = 0;
   int errors = 0;
   int n_pulses = 0;
   int m_fcw = P_FCW_DEF;
   int m_depth = P_DEP_DEF;
   logic [39:0] q[$];

   am_key_param_ctrl #(
      .FCW_DEFAULT  (32'(P_FCW_DEF)),
      .FCW_STEP     (32'(P_FCW_STEP)),
      .FCW_MIN      (32'(P_FCW_MIN)),
      .FCW_MAX      (32'(P_FCW_MAX)),
      .DEPTH_DEFAULT(8'(P_DEP_DEF)),
      .DEPTH_STEP   (8'(P_DEP_STEP)),
      .REPEAT_DELAY (20),
      .REPEAT_RATE  (10)
   ) dut (
      .clk_in      (clk),
      .rst         (rst),
      .key_code    (key_code),
      .key_pressed (key_pressed),
      .fcw         (fcw),
      .depth       (depth),
      .param_update(param_update)
   );

   always #5 clk = ~clk;

   // Scoreboard consumer: every pulse must match the oldest expected value.
   always @(negedge clk) begin
      logic [39:0] exp;
      if (rst === 1'b1 && param_update === 1'b1) begin
         n_pulses++;
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got fcw=%0d depth=%0d, required no pulse", fcw, depth);
         end else begin
            exp = q.pop_front();
            if ({fcw, depth} !== exp) begin
               errors++;
               $display("FAIL pulse_value: got fcw=%0d depth=%0d, required fcw=%0d depth=%0d",
                        fcw, depth, exp[39:8], exp[7:0]);
            end
         end
      end
   end

   task automatic model_step(input logic [3:0] code);
      int f;
      int d;
      f = m_fcw;
      d = m_depth;
      case (code)
         4'd1: f = (f + P_FCW_STEP > P_FCW_MAX) ? P_FCW_MAX : f + P_FCW_STEP;
         4'd2: f = (f - P_FCW_STEP < P_FCW_MIN) ? P_FCW_MIN : f - P_FCW_STEP;
         4'd3: d = (d + P_DEP_STEP > 255) ? 255 : d + P_DEP_STEP;
         4'd4: d = (d - P_DEP_STEP < 0) ? 0 : d - P_DEP_STEP;
         default: ;
      endcase
      if (f != m_fcw || d != m_depth) begin
         q.push_back({32'(f), 8'(d)});
         m_fcw = f;
         m_depth = d;
      end
   endtask

   task automatic press(input logic [3:0] code, input int hold);
      @(negedge clk);
      key_code = code;
      @(negedge clk);
      key_pressed = 1'b1;
      model_step(code);
      repeat (hold) @(negedge clk);
      key_pressed = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (fcw !== 32'(P_FCW_DEF) || depth !== 8'(P_DEP_DEF) || param_update !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: got fcw=%0d depth=%0d pu=%b, required fcw=%0d depth=%0d pu=0",
                  fcw, depth, param_update, P_FCW_DEF, P_DEP_DEF);
      end
      rst = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single_press;
      @(negedge clk);
      key_code = 4'd1;
      @(negedge clk);
      key_pressed = 1'b1;
      model_step(4'd1);
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++;
      if (fcw !== 32'(P_FCW_DEF) || param_update !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: got fcw=%0d pu=%b at N+2, required fcw=%0d pu=0",
                  fcw, param_update, P_FCW_DEF);
      end
      @(posedge clk);
      #1;
      checks++;
      if (fcw !== 32'(P_FCW_DEF + P_FCW_STEP) || param_update !== 1'b1) begin
         errors++;
         $display("FAIL latency_n3: got fcw=%0d pu=%b at N+3, required fcw=%0d pu=1",
                  fcw, param_update, P_FCW_DEF + P_FCW_STEP);
      end
      repeat (7) @(negedge clk);
      key_pressed = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL single_pending: got %0d outstanding, required 0", q.size());
      end
   endtask

   task automatic test_saturation;
      for (int i = 0; i < 9; i++) press(4'd3, 10);
      checks++;
      if (depth !== 8'd255) begin
         errors++;
         $display("FAIL depth_sat_high: got %0d, required 255", depth);
      end
      for (int i = 0; i < 3; i++) press(4'd2, 10);
      checks++;
      if (fcw !== 32'(P_FCW_MIN)) begin
         errors++;
         $display("FAIL fcw_sat_low: got %0d, required %0d", fcw, P_FCW_MIN);
      end
      for (int i = 0; i < 7; i++) press(4'd1, 10);
      checks++;
      if (fcw !== 32'(P_FCW_MAX)) begin
         errors++;
         $display("FAIL fcw_sat_high: got %0d, required %0d", fcw, P_FCW_MAX);
      end
      for (int i = 0; i < 2; i++) press(4'd4, 10);
      checks++;
      if (depth !== 8'd223 || q.size() != 0) begin
         errors++;
         $display("FAIL depth_down: got depth=%0d pending=%0d, required depth=223 pending=0",
                  depth, q.size());
      end
   endtask

   task automatic test_invalid_codes;
      press(4'd0, 8);
      press(4'd5, 8);
      press(4'd15, 8);
      checks++;
      if (fcw !== 32'(m_fcw) || depth !== 8'(m_depth)) begin
         errors++;
         $display("FAIL invalid_codes: got fcw=%0d depth=%0d, required fcw=%0d depth=%0d",
                  fcw, depth, m_fcw, m_depth);
      end
      @(negedge clk);
      key_code = 4'd2;
      @(negedge clk);
      key_pressed = 1'b1;
      model_step(4'd2);
      repeat (6) @(negedge clk);
      key_code = 4'd1;
      repeat (6) @(negedge clk);
      key_pressed = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (fcw !== 32'(P_FCW_MAX - P_FCW_STEP) || q.size() != 0) begin
         errors++;
         $display("FAIL code_switch: got fcw=%0d pending=%0d, required fcw=%0d pending=0",
                  fcw, q.size(), P_FCW_MAX - P_FCW_STEP);
      end
   endtask

   task automatic test_autorepeat;
      int p0;
      int exp_steps;
`ifdef KEY_AUTOREPEAT_EN
      exp_steps = 4;
`else
      exp_steps = 1;
`endif
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      m_fcw = P_FCW_DEF;
      m_depth = P_DEP_DEF;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      p0 = n_pulses;
      key_code = 4'd1;
      @(negedge clk);
      key_pressed = 1'b1;
      for (int k = 0; k < exp_steps; k++) model_step(4'd1);
      repeat (45) @(negedge clk);
      key_pressed = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (fcw !== 32'(P_FCW_DEF + exp_steps * P_FCW_STEP) || (n_pulses - p0) != exp_steps) begin
         errors++;
         $display("FAIL autorepeat: got fcw=%0d pulses=%0d, required fcw=%0d pulses=%0d",
                  fcw, n_pulses - p0, P_FCW_DEF + exp_steps * P_FCW_STEP, exp_steps);
      end
   endtask

   task automatic test_reset_mid_hold;
      @(negedge clk);
      key_code = 4'd1;
      @(negedge clk);
      key_pressed = 1'b1;
      model_step(4'd1);
      repeat (15) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (fcw !== 32'(P_FCW_DEF) || depth !== 8'(P_DEP_DEF) || param_update !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got fcw=%0d depth=%0d pu=%b, required fcw=%0d depth=%0d pu=0",
                  fcw, depth, param_update, P_FCW_DEF, P_DEP_DEF);
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pre_reset_pending: got %0d outstanding, required 0", q.size());
      end
      q.delete();
      m_fcw = P_FCW_DEF;
      m_depth = P_DEP_DEF;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);
      checks++;
      if (fcw !== 32'(P_FCW_DEF)) begin
         errors++;
         $display("FAIL held_after_reset: got fcw=%0d, required %0d", fcw, P_FCW_DEF);
      end
      key_pressed = 1'b0;
      repeat (6) @(negedge clk);
      press(4'd1, 10);
      checks++;
      if (fcw !== 32'(P_FCW_DEF + P_FCW_STEP) || q.size() != 0) begin
         errors++;
         $display("FAIL repress_after_reset: got fcw=%0d pending=%0d, required fcw=%0d pending=0",
                  fcw, q.size(), P_FCW_DEF + P_FCW_STEP);
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_saturation();
      test_invalid_codes();
      test_autorepeat();
      test_reset_mid_hold();
      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
